// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream frame generator: FSM states, the
// "no error frame" marker and the byte-pattern helper.
package axis_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Truncated to CNT_WIDTH where used; all-ones means no frame is marked.
    localparam logic [31:0] CNT_NONE = 32'hFFFF_FFFF;

    // Callers truncate the sum to DATA_WIDTH, which gives the modulo wrap.
    function automatic logic [31:0] pattern_sum(input logic [31:0] seed,
                                                input logic [31:0] frame,
                                                input logic [31:0] beat);
        return seed + frame + beat;
    endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame source: programmed number of frames of programmed length,
// incrementing byte pattern, tlast per frame, optional tuser error marking.
module axis_frame_gen
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_start,
    input  logic                  cfg_stop,
    input  logic [LEN_WIDTH-1:0]  cfg_frame_len,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_count,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [CNT_WIDTH-1:0]  cfg_err_frame,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  frames_sent,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser
);

    localparam logic [CNT_WIDTH-1:0] ERR_NONE = CNT_WIDTH'(CNT_NONE);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic [CNT_WIDTH-1:0]  err_q, err_d;
    logic                  stop_q, stop_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0]  sent_q, sent_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;
    logic                  busy_q, busy_d;

    logic [LEN_WIDTH-1:0]  start_len;
    logic [LEN_WIDTH-1:0]  beat_nx;
    logic [CNT_WIDTH-1:0]  sent_nx;
    logic                  no_more;

    function automatic logic hit_err(input logic [CNT_WIDTH-1:0] frame,
                                     input logic [CNT_WIDTH-1:0] err);
        return (frame == err) && (err != ERR_NONE);
    endfunction

    assign start_len = (cfg_frame_len == '0) ? LEN_ONE : cfg_frame_len;
    assign beat_nx   = beat_q + LEN_ONE;
    assign sent_nx   = sent_q + CNT_WIDTH'(1);
    // A stop pulse arriving on the tlast transfer cycle also ends the run.
    assign no_more   = stop_q || cfg_stop || ((count_q != '0) && (sent_nx == count_q));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        count_d   = count_q;
        gap_d     = gap_q;
        seed_d    = seed_q;
        err_d     = err_q;
        stop_d    = stop_q;
        beat_d    = beat_q;
        gap_cnt_d = gap_cnt_q;
        sent_d    = sent_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        tuser_d   = tuser_q;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d  = SEND;
                    len_d    = start_len;
                    count_d  = cfg_frame_count;
                    gap_d    = cfg_gap;
                    seed_d   = cfg_seed;
                    err_d    = cfg_err_frame;
                    stop_d   = 1'b0;
                    beat_d   = '0;
                    sent_d   = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = cfg_seed;
                    tlast_d  = (start_len == LEN_ONE);
                    tuser_d  = (start_len == LEN_ONE) && hit_err('0, cfg_err_frame);
                end
            end

            SEND: begin
                stop_d = stop_q || cfg_stop;
                if (tvalid_q && m_axis_tready) begin
                    if (!tlast_q) begin
                        beat_d  = beat_nx;
                        tdata_d = DATA_WIDTH'(pattern_sum(32'(seed_q), 32'(sent_q), 32'(beat_nx)));
                        tlast_d = (beat_nx == len_q - LEN_ONE);
                        tuser_d = (beat_nx == len_q - LEN_ONE) && hit_err(sent_q, err_q);
                    end else begin
                        sent_d  = sent_nx;
                        beat_d  = '0;
                        tlast_d = 1'b0;
                        tuser_d = 1'b0;
                        if (no_more) begin
                            state_d  = IDLE;
                            tvalid_d = 1'b0;
                        end else if (gap_q == '0) begin
                            tdata_d = DATA_WIDTH'(pattern_sum(32'(seed_q), 32'(sent_nx), 32'd0));
                            tlast_d = (len_q == LEN_ONE);
                            tuser_d = (len_q == LEN_ONE) && hit_err(sent_nx, err_q);
                        end else begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                            tvalid_d  = 1'b0;
                        end
                    end
                end
            end

            GAP: begin
                if (stop_q || cfg_stop) begin
                    state_d = IDLE;
                end else if (gap_cnt_q <= GAP_WIDTH'(1)) begin
                    // sent_q already counts the previous frame, so it is the new frame index.
                    state_d  = SEND;
                    tvalid_d = 1'b1;
                    tdata_d  = DATA_WIDTH'(pattern_sum(32'(seed_q), 32'(sent_q), 32'd0));
                    tlast_d  = (len_q == LEN_ONE);
                    tuser_d  = (len_q == LEN_ONE) && hit_err(sent_q, err_q);
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            count_q   <= '0;
            gap_q     <= '0;
            seed_q    <= '0;
            err_q     <= '0;
            stop_q    <= 1'b0;
            beat_q    <= '0;
            gap_cnt_q <= '0;
            sent_q    <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            tuser_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            count_q   <= count_d;
            gap_q     <= gap_d;
            seed_q    <= seed_d;
            err_q     <= err_d;
            stop_q    <= stop_d;
            beat_q    <= beat_d;
            gap_cnt_q <= gap_cnt_d;
            sent_q    <= sent_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            tuser_q   <= tuser_d;
            busy_q    <= busy_d;
        end
    end

    assign busy          = busy_q;
    assign frames_sent   = sent_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;

endmodule
